board_game_ctrl: RTL and testbench

Parametrised turn-based grid game controller for the VGA game top level: N×N board, configurable K-in-a-row win length, two players, wrap-around cursor, occupied-cell rejection and a sequential line scanner for win and draw detection. It sits between the debounced button synchroniser and the pixel renderer. The renderer reads board contents through a combinational query port indexed by its own pixel-derived cell coordinates.

---
 rtl/game_pkg.sv | 38 +++
 rtl/win_scanner.sv | 140 ++++++++++++++
 rtl/board_game_ctrl.sv | 175 +++++++++++++++++
 tb/tb_board_game_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the grid game controller: cell values, one-hot states
// and the four scan directions used by the win scanner.
package game_pkg;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] P1    = 2'd1;
  localparam logic [1:0] P2    = 2'd2;

  typedef enum logic [4:0] {
    S_CLEAR = 5'b00001,
    S_PLAY  = 5'b00010,
    S_CHECK = 5'b00100,
    S_WIN   = 5'b01000,
    S_DRAW  = 5'b10000
  } state_e;

  localparam int NUM_DIRS = 4;

  // Direction table: (1,0), (0,1), (1,1), (1,-1); the scanner negates for the backward side.
  function automatic logic signed [1:0] dir_dx(input logic [1:0] d);
    case (d)
      2'd0:    dir_dx = 2'sd1;
      2'd1:    dir_dx = 2'sd0;
      2'd2:    dir_dx = 2'sd1;
      default: dir_dx = 2'sd1;
    endcase
  endfunction

  function automatic logic signed [1:0] dir_dy(input logic [1:0] d);
    case (d)
      2'd0:    dir_dy = 2'sd0;
      2'd1:    dir_dy = 2'sd1;
      2'd2:    dir_dy = 2'sd1;
      default: dir_dy = -2'sd1;
    endcase
  endfunction

endpackage

// File: rtl/win_scanner.sv
// Sequential line scanner: walks WIN_LEN-1 neighbours per side, two sides per
// direction, four directions, one board read per cycle; fixed latency.
module win_scanner import game_pkg::*; #(
  parameter int BOARD_N = 3,
  parameter int WIN_LEN = 3,
  parameter int CW      = $clog2(BOARD_N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] start_x,
  input  logic [CW-1:0] start_y,
  input  logic [1:0]    start_player,
  output logic [CW-1:0] rd_x,
  output logic [CW-1:0] rd_y,
  output logic          rd_valid,
  input  logic [1:0]    rd_cell,
  output logic          done,
  output logic          win,
  output logic [1:0]    player
);

  localparam logic [2:0] LAST_STEP = 3'(WIN_LEN - 2);

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          win_q, win_d;
  logic [1:0]    dir_q, dir_d;
  logic          side_q, side_d;
  logic [2:0]    step_q, step_d;
  logic [3:0]    run_q, run_d;
  logic          alive_q, alive_d;
  logic [CW-1:0] ax_q, ax_d;
  logic [CW-1:0] ay_q, ay_d;
  logic [1:0]    ply_q, ply_d;

  logic          match;
  logic [3:0]    run_n;
  int            dx_i, dy_i, off_i, nx_i, ny_i;

  // Neighbour address: anchor + side * (step+1) * direction, bounds checked in int.
  always_comb begin
    dx_i = int'(dir_dx(dir_q));
    dy_i = int'(dir_dy(dir_q));
    if (side_q) begin
      dx_i = -dx_i;
      dy_i = -dy_i;
    end
    off_i    = int'(step_q) + 1;
    nx_i     = int'(ax_q) + dx_i * off_i;
    ny_i     = int'(ay_q) + dy_i * off_i;
    rd_valid = (nx_i >= 0) && (nx_i < BOARD_N) && (ny_i >= 0) && (ny_i < BOARD_N);
    rd_x     = nx_i[CW-1:0];
    rd_y     = ny_i[CW-1:0];
  end

  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    win_d   = win_q;
    dir_d   = dir_q;
    side_d  = side_q;
    step_d  = step_q;
    run_d   = run_q;
    alive_d = alive_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    ply_d   = ply_q;
    match   = alive_q && rd_valid && (rd_cell == ply_q);
    run_n   = run_q + 4'(match);
    if (start) begin
      busy_d  = 1'b1;
      win_d   = 1'b0;
      dir_d   = 2'd0;
      side_d  = 1'b0;
      step_d  = 3'd0;
      run_d   = 4'd1;
      alive_d = 1'b1;
      ax_d    = start_x;
      ay_d    = start_y;
      ply_d   = start_player;
    end else if (busy_q) begin
      run_d   = run_n;
      alive_d = match;
      if (step_q == LAST_STEP) begin
        step_d  = 3'd0;
        alive_d = 1'b1;
        if (!side_q) begin
          side_d = 1'b1;
        end else begin
          // End of a direction: judge the run, then restart the count.
          side_d = 1'b0;
          run_d  = 4'd1;
          if (run_n >= 4'(WIN_LEN)) win_d = 1'b1;
          if (dir_q == 2'(NUM_DIRS - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            dir_d = dir_q + 2'd1;
          end
        end
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= 1'b0;
      dir_q   <= 2'd0;
      side_q  <= 1'b0;
      step_q  <= 3'd0;
      run_q   <= 4'd1;
      alive_q <= 1'b1;
      ax_q    <= '0;
      ay_q    <= '0;
      ply_q   <= EMPTY;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      win_q   <= win_d;
      dir_q   <= dir_d;
      side_q  <= side_d;
      step_q  <= step_d;
      run_q   <= run_d;
      alive_q <= alive_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      ply_q   <= ply_d;
    end
  end

  assign done   = done_q;
  assign win    = win_q;
  assign player = ply_q;

endmodule

// File: rtl/board_game_ctrl.sv
// Turn-based N x N grid game controller: cursor, stone placement, fixed-latency
// win/draw scan, and a combinational cell query port for the renderer.
module board_game_ctrl import game_pkg::*; #(
  parameter int BOARD_N = 3,
  parameter int WIN_LEN = 3,
  parameter int CW      = $clog2(BOARD_N),
  parameter int MW      = $clog2(BOARD_N * BOARD_N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic          place,
  input  logic          new_game,
  input  logic          first_player,
  input  logic [CW-1:0] qx,
  input  logic [CW-1:0] qy,
  output logic [1:0]    q_cell,
  output logic [CW-1:0] cur_x,
  output logic [CW-1:0] cur_y,
  output logic [1:0]    turn,
  output logic [MW-1:0] moves,
  output logic [4:0]    state_q,
  output logic [1:0]    winner,
  output logic          illegal
);

  localparam int            CELLS  = BOARD_N * BOARD_N;
  localparam int            AW     = $clog2(CELLS);
  localparam logic [CW-1:0] CENTRE = CW'(BOARD_N / 2);
  localparam logic [CW-1:0] MAXC   = CW'(BOARD_N - 1);

  function automatic logic [AW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return AW'(y) * AW'(BOARD_N) + AW'(x);
  endfunction

  function automatic logic in_board(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return (int'(x) < BOARD_N) && (int'(y) < BOARD_N);
  endfunction

  logic [1:0]    board_q [CELLS];
  logic [1:0]    board_d [CELLS];
  state_e        state_d;
  logic [CW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [1:0]    turn_q, turn_d, winner_q, winner_d;
  logic [MW-1:0] moves_q, moves_d;
  logic          illegal_q, illegal_d;
  logic [4:0]    btn_prev_q, btn, rise;
  logic [AW-1:0] cur_idx;

  logic          scan_start, scan_done, scan_win, scan_rd_valid;
  logic [CW-1:0] scan_rd_x, scan_rd_y;
  logic [1:0]    scan_rd_cell, scan_player;

  win_scanner #(.BOARD_N(BOARD_N), .WIN_LEN(WIN_LEN), .CW(CW)) u_scanner (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (scan_start),
    .start_x      (cur_x_q),
    .start_y      (cur_y_q),
    .start_player (turn_q),
    .rd_x         (scan_rd_x),
    .rd_y         (scan_rd_y),
    .rd_valid     (scan_rd_valid),
    .rd_cell      (scan_rd_cell),
    .done         (scan_done),
    .win          (scan_win),
    .player       (scan_player)
  );

  always_comb begin
    q_cell = in_board(qx, qy) ? board_q[cell_idx(qx, qy)] : EMPTY;
    scan_rd_cell = scan_rd_valid ? board_q[cell_idx(scan_rd_x, scan_rd_y)] : EMPTY;
  end

  // Buttons packed in priority order: place, up, down, left, right.
  assign btn     = {place, up, down, left, right};
  assign rise    = btn & ~btn_prev_q;
  assign cur_idx = cell_idx(cur_x_q, cur_y_q);

  always_comb begin
    state_d    = state_e'(state_q);
    board_d    = board_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    turn_d     = turn_q;
    moves_d    = moves_q;
    winner_d   = winner_q;
    illegal_d  = 1'b0;
    scan_start = 1'b0;
    case (state_q)
      S_CLEAR: begin
        for (int i = 0; i < CELLS; i++) board_d[i] = EMPTY;
        moves_d  = '0;
        winner_d = EMPTY;
        cur_x_d  = CENTRE;
        cur_y_d  = CENTRE;
        turn_d   = first_player ? P2 : P1;
        state_d  = S_PLAY;
      end
      S_PLAY: begin
        if (rise[4]) begin
          if (board_q[cur_idx] == EMPTY) begin
            board_d[cur_idx] = turn_q;
            moves_d          = moves_q + MW'(1);
            scan_start       = 1'b1;
            state_d          = S_CHECK;
          end else begin
            illegal_d = 1'b1;
          end
        end else if (rise[3]) begin
          cur_y_d = (cur_y_q == '0) ? MAXC : cur_y_q - CW'(1);
        end else if (rise[2]) begin
          cur_y_d = (cur_y_q == MAXC) ? '0 : cur_y_q + CW'(1);
        end else if (rise[1]) begin
          cur_x_d = (cur_x_q == '0) ? MAXC : cur_x_q - CW'(1);
        end else if (rise[0]) begin
          cur_x_d = (cur_x_q == MAXC) ? '0 : cur_x_q + CW'(1);
        end
      end
      S_CHECK: begin
        // A win on the final cell outranks the full-board draw.
        if (scan_done) begin
          if (scan_win) begin
            winner_d = scan_player;
            state_d  = S_WIN;
          end else if (moves_q == MW'(CELLS)) begin
            state_d = S_DRAW;
          end else begin
            turn_d  = (turn_q == P1) ? P2 : P1;
            state_d = S_PLAY;
          end
        end
      end
      S_WIN, S_DRAW: begin
        if (new_game) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      for (int i = 0; i < CELLS; i++) board_q[i] <= EMPTY;
      cur_x_q    <= CENTRE;
      cur_y_q    <= CENTRE;
      turn_q     <= P1;
      moves_q    <= '0;
      winner_q   <= EMPTY;
      illegal_q  <= 1'b0;
      btn_prev_q <= 5'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      turn_q     <= turn_d;
      moves_q    <= moves_d;
      winner_q   <= winner_d;
      illegal_q  <= illegal_d;
      btn_prev_q <= btn;
    end
  end

  assign cur_x   = cur_x_q;
  assign cur_y   = cur_y_q;
  assign turn    = turn_q;
  assign moves   = moves_q;
  assign winner  = winner_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_board_game_ctrl.sv
// Bench for board_game_ctrl: a 3x3/K=3 and a 5x5/K=4 instance driven in turn,
// checked against a board-array model of the game rules.
module tb_board_game_ctrl;

  localparam logic [4:0] ST_CLEAR = 5'b00001;
  localparam logic [4:0] ST_PLAY  = 5'b00010;
  localparam logic [4:0] ST_CHECK = 5'b00100;
  localparam logic [4:0] ST_WIN   = 5'b01000;
  localparam logic [4:0] ST_DRAW  = 5'b10000;
  localparam logic [4:0] B_PLACE  = 5'b10000;
  localparam logic [4:0] B_UP     = 5'b01000;
  localparam logic [4:0] B_DOWN   = 5'b00100;
  localparam logic [4:0] B_LEFT   = 5'b00010;
  localparam logic [4:0] B_RIGHT  = 5'b00001;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] btn_v = 5'b0;
  logic       new_game_v = 1'b0;
  logic       first_player = 1'b0;
  logic [2:0] q_x = 3'd0, q_y = 3'd0;
  int         sel = 0;

  logic [4:0] b3, b5;
  logic       ng3, ng5;
  assign b3  = (sel == 0) ? btn_v : 5'b0;
  assign b5  = (sel == 1) ? btn_v : 5'b0;
  assign ng3 = (sel == 0) && new_game_v;
  assign ng5 = (sel == 1) && new_game_v;

  logic [1:0] qc3, cx3, cy3, turn3, win3;
  logic [3:0] mv3;
  logic [4:0] st3;
  logic       ill3;
  logic [1:0] qc5, turn5, win5;
  logic [2:0] cx5, cy5;
  logic [4:0] mv5, st5;
  logic       ill5;

  board_game_ctrl #(.BOARD_N(3), .WIN_LEN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .up(b3[3]), .down(b3[2]), .left(b3[1]), .right(b3[0]),
    .place(b3[4]), .new_game(ng3), .first_player(first_player), .qx(q_x[1:0]), .qy(q_y[1:0]),
    .q_cell(qc3), .cur_x(cx3), .cur_y(cy3), .turn(turn3), .moves(mv3), .state_q(st3),
    .winner(win3), .illegal(ill3)
  );

  board_game_ctrl #(.BOARD_N(5), .WIN_LEN(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .up(b5[3]), .down(b5[2]), .left(b5[1]), .right(b5[0]),
    .place(b5[4]), .new_game(ng5), .first_player(first_player), .qx(q_x), .qy(q_y),
    .q_cell(qc5), .cur_x(cx5), .cur_y(cy5), .turn(turn5), .moves(mv5), .state_q(st5),
    .winner(win5), .illegal(ill5)
  );

  logic [1:0] o_qc, o_turn, o_winner;
  logic [2:0] o_cx, o_cy;
  logic [4:0] o_moves, o_state;
  logic       o_ill;
  always_comb begin
    if (sel == 0) begin
      o_qc = qc3; o_turn = turn3; o_winner = win3; o_cx = {1'b0, cx3}; o_cy = {1'b0, cy3};
      o_moves = {1'b0, mv3}; o_state = st3; o_ill = ill3;
    end else begin
      o_qc = qc5; o_turn = turn5; o_winner = win5; o_cx = cx5; o_cy = cy5;
      o_moves = mv5; o_state = st5; o_ill = ill5;
    end
  end

  // reference model of the selected instance
  int nn = 3, kk = 3;
  int bm [8][8];
  int mx, my, mturn, mmoves, mst, mwin;
  int n_checks = 0, n_pass = 0;

  task automatic model_clear(input int fp);
    for (int x = 0; x < 8; x++) for (int y = 0; y < 8; y++) bm[x][y] = 0;
    mx = nn / 2; my = nn / 2; mturn = fp ? 2 : 1; mmoves = 0; mst = 0; mwin = 0;
  endtask

  function automatic bit line_win(input int x, input int y, input int p);
    int dxs [4];
    int dys [4];
    int cnt, cx, cy;
    dxs = '{1, 0, 1, 1};
    dys = '{0, 1, 1, -1};
    for (int d = 0; d < 4; d++) begin
      cnt = 1;
      for (int s = -1; s <= 1; s += 2) begin
        cx = x + s * dxs[d];
        cy = y + s * dys[d];
        while (cx >= 0 && cx < nn && cy >= 0 && cy < nn && bm[cx][cy] == p) begin
          cnt++;
          cx += s * dxs[d];
          cy += s * dys[d];
        end
      end
      if (cnt >= kk) return 1'b1;
    end
    return 1'b0;
  endfunction

  // driver: one button vector, model update and checks of the outcome
  task automatic act(input logic [4:0] v, input string tag);
    int cnt;
    q_x = 3'(mx); q_y = 3'(my);
    @(negedge clk); btn_v = v;
    @(negedge clk);
    if (v[4]) begin
      if (bm[mx][my] != 0) begin
        n_checks++; if (o_ill !== 1'b1) $display("FAIL %s illegal_pulse got %b exp 1", tag, o_ill); else n_pass++;
        n_checks++; if (o_moves !== 5'(mmoves)) $display("FAIL %s illegal_moves got %0d exp %0d", tag, o_moves, mmoves); else n_pass++;
        n_checks++; if (o_turn !== 2'(mturn)) $display("FAIL %s illegal_turn got %0d exp %0d", tag, o_turn, mturn); else n_pass++;
        btn_v = 5'b0;
        @(negedge clk);
        n_checks++; if (o_ill !== 1'b0 || o_state !== ST_PLAY) $display("FAIL %s illegal_end got ill=%b st=%b exp ill=0 st=%b", tag, o_ill, o_state, ST_PLAY); else n_pass++;
      end else begin
        bm[mx][my] = mturn; mmoves++;
        n_checks++; if (o_state !== ST_CHECK) $display("FAIL %s enter_check got %b exp %b", tag, o_state, ST_CHECK); else n_pass++;
        n_checks++; if (o_qc !== 2'(mturn)) $display("FAIL %s stone got %0d exp %0d", tag, o_qc, mturn); else n_pass++;
        n_checks++; if (o_moves !== 5'(mmoves)) $display("FAIL %s moves got %0d exp %0d", tag, o_moves, mmoves); else n_pass++;
        btn_v = 5'b0;
        cnt = 1;
        while (cnt < 400) begin
          @(negedge clk);
          if (o_state != ST_CHECK) break;
          cnt++;
        end
        n_checks++; if (cnt != 8 * (kk - 1) + 1) $display("FAIL %s check_cycles got %0d exp %0d", tag, cnt, 8 * (kk - 1) + 1); else n_pass++;
        if (line_win(mx, my, mturn)) begin
          mst = 1; mwin = mturn;
          n_checks++; if (o_state !== ST_WIN || o_winner !== 2'(mwin)) $display("FAIL %s verdict_win got st=%b w=%0d exp st=%b w=%0d", tag, o_state, o_winner, ST_WIN, mwin); else n_pass++;
        end else if (mmoves == nn * nn) begin
          mst = 2;
          n_checks++; if (o_state !== ST_DRAW || o_winner !== 2'd0) $display("FAIL %s verdict_draw got st=%b w=%0d exp st=%b w=0", tag, o_state, o_winner, ST_DRAW); else n_pass++;
        end else begin
          mturn = 3 - mturn;
          n_checks++; if (o_state !== ST_PLAY || o_turn !== 2'(mturn)) $display("FAIL %s verdict_play got st=%b t=%0d exp st=%b t=%0d", tag, o_state, o_turn, ST_PLAY, mturn); else n_pass++;
        end
      end
    end else begin
      if (v[3]) my = (my + nn - 1) % nn;
      else if (v[2]) my = (my + 1) % nn;
      else if (v[1]) mx = (mx + nn - 1) % nn;
      else if (v[0]) mx = (mx + 1) % nn;
      n_checks++; if (o_cx !== 3'(mx) || o_cy !== 3'(my)) $display("FAIL %s cursor got (%0d,%0d) exp (%0d,%0d)", tag, o_cx, o_cy, mx, my); else n_pass++;
      btn_v = 5'b0;
      @(negedge clk);
    end
  endtask

  task automatic goto_place(input int x, input int y, input string tag);
    while (mx != x) act(B_RIGHT, tag);
    while (my != y) act(B_DOWN, tag);
    act(B_PLACE, tag);
  endtask

  task automatic sweep_board(input string tag);
    int e;
    for (int y = 0; y < nn; y++) begin
      for (int x = 0; x <= nn; x++) begin
        q_x = 3'(x); q_y = 3'(y);
        #1;
        e = (x < nn) ? bm[x][y] : 0;
        n_checks++; if (o_qc !== 2'(e)) $display("FAIL %s cell(%0d,%0d) got %0d exp %0d", tag, x, y, o_qc, e); else n_pass++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; btn_v = 5'b0; new_game_v = 1'b0; first_player = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_clear(0);
  endtask

  task automatic do_new_game(input int fp, input string tag);
    @(negedge clk); new_game_v = 1'b1; first_player = fp[0];
    @(negedge clk); new_game_v = 1'b0;
    n_checks++; if (o_state !== ST_CLEAR) $display("FAIL %s ng_clear got %b exp %b", tag, o_state, ST_CLEAR); else n_pass++;
    @(negedge clk);
    model_clear(fp);
    n_checks++; if (o_state !== ST_PLAY) $display("FAIL %s ng_play got %b exp %b", tag, o_state, ST_PLAY); else n_pass++;
    n_checks++; if (o_turn !== 2'(mturn) || o_moves !== 5'd0 || o_winner !== 2'd0) $display("FAIL %s ng_regs got t=%0d m=%0d w=%0d exp t=%0d m=0 w=0", tag, o_turn, o_moves, o_winner, mturn); else n_pass++;
    n_checks++; if (o_cx !== 3'(mx) || o_cy !== 3'(my)) $display("FAIL %s ng_cursor got (%0d,%0d) exp (%0d,%0d)", tag, o_cx, o_cy, mx, my); else n_pass++;
    sweep_board(tag);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s; nn = (s == 0) ? 3 : 5;
      q_x = 3'(nn / 2); q_y = 3'(nn / 2);
      #1;
      n_checks++; if (o_state !== ST_CLEAR) $display("FAIL reset_state[%0d] got %b exp %b", s, o_state, ST_CLEAR); else n_pass++;
      n_checks++; if (o_cx !== 3'(nn / 2) || o_cy !== 3'(nn / 2)) $display("FAIL reset_cursor[%0d] got (%0d,%0d) exp (%0d,%0d)", s, o_cx, o_cy, nn / 2, nn / 2); else n_pass++;
      n_checks++; if (o_turn !== 2'd1 || o_moves !== 5'd0 || o_winner !== 2'd0 || o_ill !== 1'b0 || o_qc !== 2'd0) $display("FAIL reset_regs[%0d] got t=%0d m=%0d w=%0d i=%b c=%0d exp t=1 m=0 w=0 i=0 c=0", s, o_turn, o_moves, o_winner, o_ill, o_qc); else n_pass++;
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      n_checks++; if (o_state !== ST_PLAY) $display("FAIL reset_release[%0d] got %b exp %b", s, o_state, ST_PLAY); else n_pass++;
    end
    sel = 0; nn = 3; kk = 3; model_clear(0);
  endtask

  task automatic test_cursor();
    repeat (3) act(B_RIGHT, "cursor_right");
    n_checks++; if (o_cx !== 3'd1) $display("FAIL cursor_wrap_x got %0d exp 1", o_cx); else n_pass++;
    act(B_UP, "cursor_up");
    act(B_UP, "cursor_up_wrap");
    n_checks++; if (o_cy !== 3'd2) $display("FAIL cursor_wrap_y got %0d exp 2", o_cy); else n_pass++;
    act(B_LEFT | B_RIGHT | B_DOWN, "cursor_priority");
  endtask

  task automatic test_row_win();
    goto_place(0, 0, "row_p1a");
    goto_place(0, 1, "row_p2a");
    goto_place(1, 0, "row_p1b");
    goto_place(1, 1, "row_p2b");
    goto_place(2, 0, "row_p1c");
    n_checks++; if (o_state !== ST_WIN || o_winner !== 2'd1) $display("FAIL row_win got st=%b w=%0d exp st=%b w=1", o_state, o_winner, ST_WIN); else n_pass++;
    @(negedge clk); btn_v = B_PLACE | B_RIGHT;
    @(negedge clk); btn_v = 5'b0;
    n_checks++; if (o_state !== ST_WIN || o_cx !== 3'(mx) || o_moves !== 5'd5) $display("FAIL frozen_win got st=%b x=%0d m=%0d exp st=%b x=%0d m=5", o_state, o_cx, o_moves, ST_WIN, mx); else n_pass++;
    sweep_board("row_board");
    do_new_game(0, "row_ng");
  endtask

  task automatic test_illegal();
    goto_place(1, 1, "illegal_first");
    act(B_PLACE, "illegal_second");
  endtask

  task automatic test_draw();
    int seq [18];
    do_reset();
    seq = '{0,0, 1,0, 2,0, 1,1, 0,1, 2,1, 1,2, 0,2, 2,2};
    for (int i = 0; i < 9; i++) begin
      while (mx != seq[2*i]) act(B_LEFT, "draw_move");
      while (my != seq[2*i+1]) act(B_UP, "draw_move");
      act(B_PLACE, "draw_place");
    end
    n_checks++; if (o_state !== ST_DRAW || o_moves !== 5'd9) $display("FAIL draw_final got st=%b m=%0d exp st=%b m=9", o_state, o_moves, ST_DRAW); else n_pass++;
    do_new_game(1, "draw_ng");
    n_checks++; if (o_turn !== 2'd2) $display("FAIL draw_ng_turn got %0d exp 2", o_turn); else n_pass++;
  endtask

  task automatic test_random_games(input int games);
    logic [4:0] v;
    int r, acts;
    for (int g = 0; g < games; g++) begin
      acts = 0;
      while (mst == 0 && acts < 80) begin
        r = $urandom_range(0, 9);
        if (r < 3) v = B_PLACE;
        else if (r < 4) v = 5'($urandom_range(1, 31));
        else v = 5'($urandom_range(1, 15));
        act(v, "random");
        acts++;
      end
      sweep_board("random_board");
      if (mst != 0) do_new_game($urandom_range(0, 1), "random_ng");
      else do_reset();
    end
  endtask

  task automatic test_anti_diag();
    do_reset();
    sel = 1; nn = 5; kk = 4; model_clear(0);
    goto_place(0, 0, "ad_p1a");
    goto_place(4, 0, "ad_p2a");
    goto_place(0, 1, "ad_p1b");
    goto_place(3, 1, "ad_p2b");
    goto_place(0, 3, "ad_p1c");
    goto_place(2, 2, "ad_p2c");
    n_checks++; if (o_state !== ST_PLAY || o_winner !== 2'd0) $display("FAIL ad_three got st=%b w=%0d exp st=%b w=0", o_state, o_winner, ST_PLAY); else n_pass++;
    goto_place(4, 4, "ad_p1d");
    goto_place(1, 3, "ad_p2d");
    n_checks++; if (o_state !== ST_WIN || o_winner !== 2'd2) $display("FAIL ad_win got st=%b w=%0d exp st=%b w=2", o_state, o_winner, ST_WIN); else n_pass++;
    do_new_game(0, "ad_ng");
  endtask

  task automatic test_reset_mid_check();
    do_reset();
    while (mx != 3) act(B_RIGHT, "midrst_move");
    while (my != 3) act(B_DOWN, "midrst_move");
    q_x = 3'd3; q_y = 3'd3;
    @(negedge clk); btn_v = B_PLACE;
    @(negedge clk); btn_v = 5'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (o_state !== ST_CHECK) $display("FAIL midrst_in_check got %b exp %b", o_state, ST_CHECK); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (o_state !== ST_CLEAR || o_moves !== 5'd0 || o_winner !== 2'd0 || o_turn !== 2'd1 || o_ill !== 1'b0) $display("FAIL midrst_regs got st=%b m=%0d w=%0d t=%0d i=%b exp st=%b m=0 w=0 t=1 i=0", o_state, o_moves, o_winner, o_turn, o_ill, ST_CLEAR); else n_pass++;
    n_checks++; if (o_cx !== 3'd2 || o_cy !== 3'd2 || o_qc !== 2'd0) $display("FAIL midrst_board got (%0d,%0d) c=%0d exp (2,2) c=0", o_cx, o_cy, o_qc); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++; if (o_state !== ST_PLAY || o_winner !== 2'd0 || o_moves !== 5'd0) $display("FAIL midrst_after got st=%b w=%0d m=%0d exp st=%b w=0 m=0", o_state, o_winner, o_moves, ST_PLAY); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cursor();
    test_row_win();
    test_illegal();
    test_draw();
    test_random_games(3);
    test_anti_diag();
    test_random_games(3);
    test_reset_mid_check();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
